// File: rtl/multicycle_main_controller.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   opcode       IR[31:26], looked at only in DECODE
//   zero         ALU zero flag, looked at only in BRANCH
//   pc_load      PC enable (taken-branch qualified by zero)
//   i_or_d       memory address mux: 0=PC, 1=ALUOut
//   mem_read     memory read strobe
//   mem_write    memory write strobe
//   ir_write     instruction register load
//   mem_to_reg   RF write data: 0=ALUOut, 1=MDR
//   reg_dst      RF write address: 0=rt, 1=rd
//   reg_write    RF write enable
//   alu_src_a    0=PC, 1=A
//   alu_src_b    00=B, 01=4, 10=imm, 11=imm<<2
//   alu_op       00=add, 01=sub, 10=func field
//   pc_src       00=ALU result, 01=ALUOut, 10=jump target
//   instr_done   pulse in the final state of each instruction
//   illegal_op   pulse in DECODE for an unrecognised opcode
module multicycle_main_controller #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_load,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_ADDI_EXEC = 4'd8,
        S_ADDI_WB   = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    // Registered Moore controls. pc_uncond is the unconditional PC
    // enable; is_branch and is_decode gate the two inputs that are
    // combined combinationally (zero and opcode).
    typedef struct packed {
        logic       pc_uncond;
        logic       is_branch;
        logic       is_decode;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    state_t state_q;
    ctrl_t  ctrl_q;
    logic   armed_q;
    logic   store_q;

    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW,
            OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_uncond = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.is_decode = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = 2'b01;
                c.pc_src     = 2'b01;
                c.is_branch  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_src     = 2'b10;
                c.pc_uncond  = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_of(
        input state_t     s,
        input logic [5:0] op,
        input logic       st
    );
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH: n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = S_MEM_ADDR;
                    OP_RTYPE:     n = S_R_EXEC;
                    OP_BEQ:       n = S_BRANCH;
                    OP_J:         n = S_JUMP;
                    OP_ADDI:      n = S_ADDI_EXEC;
                    default:      n = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  n = st ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  n = S_MEM_WB;
            S_R_EXEC:    n = S_R_WB;
            S_ADDI_EXEC: n = S_ADDI_WB;
            default:     n = S_FETCH;
        endcase
        return n;
    endfunction

    // After reset release the first edge only arms the FSM and loads
    // the FETCH controls, so the first FETCH after reset runs with all
    // strobes low. An unreachable encoding takes the same path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= '0;
            armed_q <= 1'b0;
            store_q <= 1'b0;
        end else if (!armed_q) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_of(S_FETCH);
            armed_q <= 1'b1;
        end else if (state_q > S_JUMP) begin
            state_q <= S_FETCH;
            ctrl_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= next_of(state_q, opcode, store_q);
            ctrl_q  <= ctrl_of(next_of(state_q, opcode, store_q));
            if (state_q == S_DECODE) begin
                store_q <= (opcode == OP_SW);
            end
        end
    end

    assign pc_load    = ctrl_q.pc_uncond | (ctrl_q.is_branch & zero);
    assign illegal_op = ctrl_q.is_decode & ~is_legal(opcode);
    assign i_or_d     = ctrl_q.i_or_d;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign ir_write   = ctrl_q.ir_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_dst    = ctrl_q.reg_dst;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign pc_src     = ctrl_q.pc_src;
    assign instr_done = ctrl_q.instr_done;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Bench for multicycle_main_controller.
// Expected per-cycle control vectors are queued per instruction and popped each cycle.
module tb_multicycle_main_controller;

    localparam int FE = 0;
    localparam int DE = 1;
    localparam int MA = 2;
    localparam int MR = 3;
    localparam int MW = 4;
    localparam int MX = 5;
    localparam int RE = 6;
    localparam int RW = 7;
    localparam int AE = 8;
    localparam int AW = 9;
    localparam int BR = 10;
    localparam int JP = 11;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_load;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;

    int total;
    int bad;
    int cyc_cnt;
    int done_cnt;
    int wr_cnt;

    logic [16:0] exp_q[$];
    int          st_q[$];

    multicycle_main_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .pc_load    (pc_load),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] cur();
        return {pc_load, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src,
                instr_done, illegal_op};
    endfunction

    // Reference control table, written straight from the state list.
    function automatic logic [16:0] ev(
        input int s, input logic z, input logic ill
    );
        logic pl, iod, mr, mw, irw, m2r, rd, rw, sa, dn, il;
        logic [1:0] sb, ao, ps;
        {pl, iod, mr, mw, irw, m2r, rd, rw, sa, dn, il} = '0;
        sb = 2'b00;
        ao = 2'b00;
        ps = 2'b00;
        case (s)
            FE: begin pl = 1; mr = 1; irw = 1; sb = 2'b01; end
            DE: begin sb = 2'b11; il = ill; end
            MA: begin sa = 1; sb = 2'b10; end
            MR: begin mr = 1; iod = 1; end
            MW: begin rw = 1; m2r = 1; dn = 1; end
            MX: begin mw = 1; iod = 1; dn = 1; end
            RE: begin sa = 1; ao = 2'b10; end
            RW: begin rw = 1; rd = 1; dn = 1; end
            AE: begin sa = 1; sb = 2'b10; end
            AW: begin rw = 1; dn = 1; end
            BR: begin
                sa = 1; ao = 2'b01; ps = 2'b01;
                pl = z; dn = 1;
            end
            JP: begin ps = 2'b10; pl = 1; dn = 1; end
            default: ;
        endcase
        return {pl, iod, mr, mw, irw, m2r, rd, rw,
                sa, sb, ao, ps, dn, il};
    endfunction

    // Queue the expected cycle sequence for one instruction.
    task automatic push_instr(input logic [5:0] op, input logic z);
        int seq[$];
        logic ill;
        ill = 1'b0;
        seq = {FE, DE};
        case (op)
            6'b100011: seq = {seq, MA, MR, MW};
            6'b101011: seq = {seq, MA, MX};
            6'b000000: seq = {seq, RE, RW};
            6'b001000: seq = {seq, AE, AW};
            6'b000100: seq = {seq, BR};
            6'b000010: seq = {seq, JP};
            default:   ill = 1'b1;
        endcase
        foreach (seq[i]) begin
            st_q.push_back(seq[i]);
            exp_q.push_back(ev(seq[i], z, ill));
        end
    endtask

    // Entered at a negedge with the DUT in FETCH; drains the queue.
    task automatic drain(
        input string nm, input logic [5:0] op, input logic z
    );
        int s;
        logic [16:0] e;
        logic [16:0] g;
        cyc_cnt  = 0;
        done_cnt = 0;
        wr_cnt   = 0;
        while (exp_q.size() > 0) begin
            s = st_q.pop_front();
            e = exp_q.pop_front();
            opcode = (s == DE) ? op : 6'bx;
            zero   = (s == BR) ? z : 1'bx;
            #1;
            g = cur();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s cyc%0d st%0d got=%b exp=%b",
                         nm, cyc_cnt, s, g, e);
            end
            total++;
            if ((mem_read & mem_write) !== 1'b0 ||
                (reg_write & mem_write) !== 1'b0) begin
                bad++;
                $display("FAIL %s excl cyc%0d got=%b exp=0",
                         nm, cyc_cnt, g);
            end
            if (instr_done === 1'b1) done_cnt++;
            if (mem_write === 1'b1) wr_cnt++;
            cyc_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        opcode = 6'b0;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (cur() !== 17'b0) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=0", cur());
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (cur() !== 17'b0) begin
            bad++;
            $display("FAIL reset_release got=%b exp=0", cur());
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (cur() !== ev(FE, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset_fetch got=%b exp=%b",
                     cur(), ev(FE, 1'b0, 1'b0));
        end
    endtask

    task automatic test_lw;
        push_instr(6'b100011, 1'b0);
        drain("lw", 6'b100011, 1'b0);
        total++;
        if (cyc_cnt !== 5 || done_cnt !== 1) begin
            bad++;
            $display("FAIL lw_len got=%0d/%0d exp=5/1",
                     cyc_cnt, done_cnt);
        end
    endtask

    task automatic test_rtype;
        push_instr(6'b000000, 1'b0);
        drain("rtype", 6'b000000, 1'b0);
        total++;
        if (cyc_cnt !== 4 || done_cnt !== 1) begin
            bad++;
            $display("FAIL r_len got=%0d/%0d exp=4/1",
                     cyc_cnt, done_cnt);
        end
    endtask

    task automatic test_beq;
        push_instr(6'b000100, 1'b1);
        drain("beq_taken", 6'b000100, 1'b1);
        total++;
        if (cyc_cnt !== 3) begin
            bad++;
            $display("FAIL beq1_len got=%0d exp=3", cyc_cnt);
        end
        push_instr(6'b000100, 1'b0);
        drain("beq_not", 6'b000100, 1'b0);
        total++;
        if (cyc_cnt !== 3) begin
            bad++;
            $display("FAIL beq0_len got=%0d exp=3", cyc_cnt);
        end
    endtask

    task automatic test_illegal;
        push_instr(6'b111111, 1'b0);
        drain("illegal", 6'b111111, 1'b0);
        total++;
        if (cyc_cnt !== 2 || done_cnt !== 0) begin
            bad++;
            $display("FAIL ill_len got=%0d/%0d exp=2/0",
                     cyc_cnt, done_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int sum;
        sum = 0;
        push_instr(6'b101011, 1'b0);
        drain("sw", 6'b101011, 1'b0);
        sum += cyc_cnt;
        total++;
        if (wr_cnt !== 1) begin
            bad++;
            $display("FAIL sw_wr got=%0d exp=1", wr_cnt);
        end
        push_instr(6'b000010, 1'b0);
        drain("j", 6'b000010, 1'b0);
        sum += cyc_cnt;
        push_instr(6'b001000, 1'b0);
        drain("addi", 6'b001000, 1'b0);
        sum += cyc_cnt;
        total++;
        if (sum !== 11) begin
            bad++;
            $display("FAIL b2b_len got=%0d exp=11", sum);
        end
    endtask

    task automatic test_reset_mid;
        opcode = 6'bx;
        zero   = 1'bx;
        @(posedge clk);
        @(negedge clk);
        opcode = 6'b000000;
        @(posedge clk);
        @(negedge clk);
        opcode = 6'bx;
        #1;
        total++;
        if (cur() !== ev(RE, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL mid_rexec got=%b exp=%b",
                     cur(), ev(RE, 1'b0, 1'b0));
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (cur() !== 17'b0) begin
            bad++;
            $display("FAIL mid_reset got=%b exp=0", cur());
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (cur() !== 17'b0) begin
            bad++;
            $display("FAIL mid_release got=%b exp=0", cur());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_lw();
        push_instr(6'b000010, 1'b0);
        drain("j_tail", 6'b000010, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
